// File: rtl/zeroriscy_loader_pkg.sv
// Shared types and constants for the zero-riscy SRAM loader.
package zeroriscy_loader_pkg;

  localparam int unsigned LEN_W_DEFAULT  = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned ADDR_STEP      = 4;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    WAIT_WR,
    VERIFY_RD,
    VERIFY_WAIT,
    FIN
  } loader_state_t;

endpackage

// File: rtl/zeroriscy_byte_packer.sv
// Packs an 8-bit byte stream little-endian into 32-bit words.
module zeroriscy_byte_packer
  import zeroriscy_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_ready_c_o
);

  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (accept_i) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_i;
      idx_q                        <= idx_q + IDX_W'(1);
    end
  end

  // High in the cycle the last byte of a word is being taken.
  assign word_ready_c_o = accept_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word_o         = word_q;

endmodule

// File: rtl/zeroriscy_sram_loader.sv
// Streams bytes into SRAM as 32-bit words over the zero-riscy data port.
// Optional read-back verification is enabled by defining SRAM_LOADER_VERIFY_EN.
module zeroriscy_sram_loader
  import zeroriscy_loader_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             m_req,
  output logic             m_we,
  output logic [3:0]       m_be,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  input  logic             m_gnt,
  input  logic             m_rvalid,
  input  logic             m_err,
  output logic             busy,
  output logic             done,
  output logic             err
);

  loader_state_t     state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              s_ready_q, s_ready_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [3:0]        m_be_q, m_be_d;
  logic              start_acc;
  logic              advance;
  logic              word_ready;
  logic [WORD_W-1:0] word;

  zeroriscy_byte_packer u_packer (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .clear_i        (start_acc),
    .accept_i       (s_valid && s_ready_q),
    .byte_i         (s_data),
    .word_o         (word),
    .word_ready_c_o (word_ready)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    start_acc = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          err_d     = 1'b0;
          addr_d    = {base_addr[31:2], 2'b00};
          cnt_d     = len_words;
          state_d   = (len_words == '0) ? FIN : COLLECT;
        end
      end
      COLLECT: if (word_ready) state_d = WRITE;
      WRITE:   if (m_gnt) state_d = WAIT_WR;
      WAIT_WR: begin
        if (m_rvalid) begin
          if (m_err) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
`ifdef SRAM_LOADER_VERIFY_EN
            state_d = VERIFY_RD;
`else
            advance = 1'b1;
`endif
          end
        end
      end
`ifdef SRAM_LOADER_VERIFY_EN
      VERIFY_RD: if (m_gnt) state_d = VERIFY_WAIT;
      VERIFY_WAIT: begin
        if (m_rvalid) begin
          if (m_err || (m_rdata != word)) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            advance = 1'b1;
          end
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      addr_d  = addr_q + 32'(ADDR_STEP);
      cnt_d   = cnt_q - LEN_W'(1);
      state_d = (cnt_q == LEN_W'(1)) ? FIN : COLLECT;
    end

    // Outputs follow the next state so they line up with the state register.
    done_d    = (state_q == FIN);
    busy_d    = (state_d != IDLE);
    s_ready_d = (state_d == COLLECT);
    m_req_d   = (state_d == WRITE) || (state_d == VERIFY_RD);
    m_we_d    = (state_d == WRITE);
    m_be_d    = m_req_d ? 4'hF : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      s_ready_q <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      s_ready_q <= s_ready_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
    end
  end

`ifdef SRAM_LOADER_VERIFY_EN
  logic unused_inputs;
  assign unused_inputs = ^base_addr[1:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{m_rdata, base_addr[1:0]};
`endif

  assign s_ready = s_ready_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = addr_q;
  assign m_wdata = word;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_zeroriscy_sram_loader.sv
// Scoreboard bench for zeroriscy_sram_loader with a zero-riscy style SRAM responder.
module tb_zeroriscy_sram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len_words;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_gnt, m_rvalid, m_err;
  logic        busy, done, err;

  zeroriscy_sram_loader #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len_words(len_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0, errors = 0;
  int          grants = 0, stall_cycles = 0, done_cnt = 0;
  int          stall_cfg = 0, wait_cnt = 0;
  bit          inj_wr_err = 1'b0, corrupt_rd = 1'b0;
  bit          granted, cap_we;
  logic [31:0] cap_addr, cap_wdata;

`ifdef SRAM_LOADER_VERIFY_EN
  localparam int REQS_PER_WORD = 2;
`else
  localparam int REQS_PER_WORD = 1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = data;
    exp_q.push_back(r);
  endtask

  // A written word, followed by its read-back when verification is built in.
  task automatic push_word(input logic [31:0] addr, input logic [31:0] data);
    push_req(1'b1, addr, data);
`ifdef SRAM_LOADER_VERIFY_EN
    push_req(1'b0, addr, data);
`endif
  endtask

  // Memory-side monitor: every presented request is checked against the queue head.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n && m_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'(m_req), 32'd0);
        end else begin
          chk("req_we", 32'(m_we), 32'(exp_q[0].we));
          chk("req_addr", m_addr, exp_q[0].addr);
          chk("req_be", 32'(m_be), 32'hF);
          if (exp_q[0].we) chk("req_wdata", m_wdata, exp_q[0].wdata);
          if (m_gnt) begin
            void'(exp_q.pop_front());
            grants++;
          end else begin
            stall_cycles++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n && done) done_cnt++;
    end
  end

  // Responder: grant after stall_cfg waiting cycles, rvalid exactly one cycle after grant.
  initial begin
    m_gnt = 1'b0; m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      granted  = m_gnt;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      m_rdata  = '0;
      if (!rst_n) begin
        wait_cnt = 0;
      end else if (granted) begin
        m_rvalid = 1'b1;
        if (cap_we) begin
          mem[cap_addr] = cap_wdata;
          m_err         = inj_wr_err;
          inj_wr_err    = 1'b0;
        end else begin
          m_rdata = (mem.exists(cap_addr) ? mem[cap_addr] : 32'h0) ^ {31'h0, corrupt_rd};
        end
      end else if (m_req) begin
        if (wait_cnt == stall_cfg) begin
          m_gnt     = 1'b1;
          wait_cnt  = 0;
          cap_we    = m_we;
          cap_addr  = m_addr;
          cap_wdata = m_wdata;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] base, input logic [15:0] len);
    @(negedge clk);
    start = 1'b1; base_addr = base; len_words = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] first, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = first + 8'(i);
      t = 0;
      while (!s_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) begin
        chk("byte_timeout", 32'(t), 32'd0);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  // Full load: start, feed n bytes, wait for completion and check the end state.
  task automatic run_load(input string name, input logic [31:0] base, input logic [15:0] len,
                          input logic [7:0] first, input int n, input logic exp_err);
    int d0, t;
    d0 = done_cnt;
    do_start(base, len);
    send_bytes(first, n);
    t = 0;
    while (done_cnt == d0 && t < 500) begin
      @(negedge clk); #2;
      t++;
    end
    if (t >= 500) chk({name, "_done_timeout"}, 32'(t), 32'd0);
    repeat (4) @(negedge clk);
    #2;
    chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int g0, s0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len_words = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_flags", {27'd0, s_ready, busy, done, err, 1'b0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_m_req", 32'(m_req), 32'd0);

    // Two words, little-endian packing, address step.
    push_word(32'h0000_1000, 32'h0403_0201);
    push_word(32'h0000_1004, 32'h0807_0605);
    run_load("basic", 32'h0000_1000, 16'd2, 8'h01, 8, 1'b0);

    // Zero-length load: done two cycles after start, no requests.
    g0 = grants;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_2000; len_words = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done_early", 32'(done), 32'd0);
    chk("len0_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    chk("len0_done_single", 32'(done), 32'd0);
    chk("len0_no_req", 32'(grants - g0), 32'd0);

    // Grant held off five cycles; request must stay stable.
    g0 = grants; s0 = stall_cycles; stall_cfg = 5;
    push_word(32'h0000_2000, 32'hA4A3_A2A1);
    run_load("stall", 32'h0000_2000, 16'd1, 8'hA1, 4, 1'b0);
    chk("stall_cycles", 32'(stall_cycles - s0), 32'(5 * REQS_PER_WORD));
    chk("stall_grants", 32'(grants - g0), 32'(REQS_PER_WORD));
    stall_cfg = 0;

    // Write error on first word: abort with err, no further request.
    g0 = grants; inj_wr_err = 1'b1;
    push_req(1'b1, 32'h0000_3000, 32'h1413_1211);
    run_load("wr_err", 32'h0000_3000, 16'd2, 8'h11, 4, 1'b1);
    chk("wr_err_grants", 32'(grants - g0), 32'd1);
    do_start(32'h0000_3100, 16'd0);
    chk("err_cleared_by_start", 32'(err), 32'd0);
    repeat (3) @(negedge clk);

    // Address wrap, plus a start pulse while busy that must be ignored.
    push_word(32'hFFFF_FFFC, 32'h2423_2221);
    push_word(32'h0000_0000, 32'h2827_2625);
    begin
      int d0, t;
      d0 = done_cnt;
      do_start(32'hFFFF_FFFC, 16'd2);
      do_start(32'h0000_5000, 16'd0);
      send_bytes(8'h21, 8);
      t = 0;
      while (done_cnt == d0 && t < 500) begin
        @(negedge clk); #2;
        t++;
      end
      repeat (4) @(negedge clk);
      #2;
      chk("wrap_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("wrap_err", 32'(err), 32'd0);
      chk("wrap_queue_left", 32'(exp_q.size()), 32'd0);
    end

    // Low address bits are dropped.
    push_word(32'h0000_4000, 32'h3433_3231);
    run_load("unaligned", 32'h0000_4003, 16'd1, 8'h31, 4, 1'b0);

    // Reset mid-word discards the partial word.
    do_start(32'h0000_7000, 16'd1);
    send_bytes(8'hE1, 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #2;
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wdata", m_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #2;
    chk("midrst_no_req", 32'(m_req), 32'd0);
    push_word(32'h0000_7100, 32'hB4B3_B2B1);
    run_load("after_rst", 32'h0000_7100, 16'd1, 8'hB1, 4, 1'b0);

`ifdef SRAM_LOADER_VERIFY_EN
    // Corrupted read-back flags err after the first read.
    corrupt_rd = 1'b1;
    push_req(1'b1, 32'h0000_6000, 32'h4443_4241);
    push_req(1'b0, 32'h0000_6000, 32'h4443_4241);
    run_load("verify_bad", 32'h0000_6000, 16'd2, 8'h41, 4, 1'b1);
    corrupt_rd = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
